// File: rtl/mnn_bram_pkg.sv
// Shared constants and FSM encoding for the MNIST BRAM port-B reader.
package mnn_bram_pkg;
   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned BRAM_DEPTH = 1 << ADDR_W_DEF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/bram_portb_streamer_fifo.sv
// Shift-register output FIFO: entry 0 is the registered stream head, unused entries are kept zero.
module stream_fifo
   import mnn_bram_pkg::*;
#(
   parameter int unsigned W     = DATA_W_DEF + 1,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             s_axi_aclk,
   input  logic             s_axi_aresetn,
   input  logic             push,
   input  logic [W-1:0]     push_data,
   input  logic             pop,
   output logic [W-1:0]     head,
   output logic             valid,
   output logic [CNT_W-1:0] count
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [W-1:0]     mem [DEPTH];
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] wr_idx;
   logic             valid_q;
   logic             do_pop;

   always_comb begin
      do_pop  = pop && valid_q;
      cnt_nxt = cnt;
      if (push && !do_pop)
         cnt_nxt = cnt + 1'b1;
      else if (!push && do_pop)
         cnt_nxt = cnt - 1'b1;
      wr_idx = do_pop ? IDX_W'(cnt - 1'b1) : IDX_W'(cnt);
   end

   // Zero fill on shift keeps entries above the count at zero, so an empty head reads as 0.
   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         cnt     <= '0;
         valid_q <= 1'b0;
      end else begin
         if (do_pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++)
               mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
         end
         if (push)
            mem[wr_idx] <= push_data;
         cnt     <= cnt_nxt;
         valid_q <= (cnt_nxt != '0);
      end
   end

   assign head  = mem[0];
   assign valid = valid_q;
   assign count = cnt;
endmodule

// File: rtl/bram_portb_streamer.sv
// Reads LEN words from BRAM port B starting at BASE and streams them out as valid/ready beats.
module bram_portb_streamer
   import mnn_bram_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned READ_LAT   = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              s_axi_aclk,
   input  logic              s_axi_aresetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] BRAM_PORTB_addr,
   output logic              BRAM_PORTB_en,
   output logic [3:0]        BRAM_PORTB_we,
   output logic [DATA_W-1:0] BRAM_PORTB_din,
   output logic              BRAM_PORTB_rst,
   input  logic [DATA_W-1:0] BRAM_PORTB_dout,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   state_t              state;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W:0]     remaining;
   logic [READ_LAT-1:0] pipe_v, pipe_last;
   logic [CNT_W-1:0]    fifo_count, inflight;
   logic [DATA_W:0]     head;
   logic                rd_en, pop;

   // The read enable is decided from current occupancy so a full-rate burst fits in READ_LAT+2 entries.
   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < READ_LAT; i++)
         inflight = inflight + CNT_W'(pipe_v[i]);
      rd_en = (state == ST_RUN) && (remaining != '0) &&
              (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH));
      pop   = m_tvalid && m_tready;
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         pipe_v    <= '0;
         pipe_last <= '0;
      end else begin
         pipe_v[0]    <= rd_en;
         pipe_last[0] <= rd_en && (remaining == (ADDR_W+1)'(1));
         for (int unsigned i = 1; i < READ_LAT; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_last[i] <= pipe_last[i-1];
         end
      end
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state     <= ST_IDLE;
         addr_q    <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     addr_q    <= base_addr;
                     remaining <= len;
                     busy      <= 1'b1;
                     state     <= ST_RUN;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (rd_en) begin
                  addr_q    <= addr_q + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == (ADDR_W+1)'(1))
                     state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (pop && m_tlast) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   stream_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .s_axi_aclk    (s_axi_aclk),
      .s_axi_aresetn (s_axi_aresetn),
      .push          (pipe_v[READ_LAT-1]),
      .push_data     ({pipe_last[READ_LAT-1], BRAM_PORTB_dout}),
      .pop           (pop),
      .head          (head),
      .valid         (m_tvalid),
      .count         (fifo_count)
   );

   assign m_tdata         = head[DATA_W-1:0];
   assign m_tlast         = head[DATA_W];
   assign BRAM_PORTB_addr = addr_q;
   assign BRAM_PORTB_en   = rd_en;
   assign BRAM_PORTB_we   = 4'b0000;
   assign BRAM_PORTB_din  = '0;
   assign BRAM_PORTB_rst  = 1'b0;
endmodule
